// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller, LSB first, one bit per clock
// Two cascaded half adders plus a carry flop; the result is published only on the completion edge.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic p, g1, s, g2;
  // The LSB of acc is shifted out every cycle and never observed.
  logic unused_acc_lsb;

  assign p  = sa_q[0] ^ sb_q[0];
  assign g1 = sa_q[0] & sb_q[0];
  assign s  = p ^ c_q;
  assign g2 = p & c_q;
  assign unused_acc_lsb = acc_q[0];

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d   = g1 | g2;
        acc_d = {s, acc_q[WIDTH-1:1]};
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
          sum_d   = acc_d;
          cout_d  = g1 | g2;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Status flags decode the state register directly, so no input reaches an output combinationally.
  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed bench for serial_adder_ctrl at WIDTH 8 and 4
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int         checks;
  int         errors;
  logic [7:0] hold_sum;
  logic       hold_cout;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the falling edge right after the accept edge; returns at the falling edge
  // right after the completion edge.
  task automatic op_check(input logic [7:0] es, input logic ec, input int pulse_at,
                          input bit keep_start);
    for (int k = 0; k < 8; k++) begin
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_done", {31'd0, done}, 32'd0);
      chk("run_sum_hold", {24'd0, sum}, {24'd0, hold_sum});
      chk("run_cout_hold", {31'd0, cout}, {31'd0, hold_cout});
      if (!keep_start) begin
        if (k == pulse_at) begin
          start = 1'b1;
          a     = 8'hF0;
          b     = 8'h0F;
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("fin_done", {31'd0, done}, 32'd1);
    chk("fin_busy", {31'd0, busy}, 32'd0);
    chk("fin_sum", {24'd0, sum}, {24'd0, es});
    chk("fin_cout", {31'd0, cout}, {31'd0, ec});
    hold_sum  = es;
    hold_cout = ec;
  endtask

  initial begin
    clk       = 1'b0;
    checks    = 0;
    errors    = 0;
    hold_sum  = 8'h00;
    hold_cout = 1'b0;
    rst       = 1'b1;
    start     = 1'b1;
    a         = 8'hFF;
    b         = 8'hFF;
    start4    = 1'b0;
    a4        = 4'h0;
    b4        = 4'h0;

    // Reset dominates a pending start
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {24'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);

    // Carry ripple: FF + 01 = 1_00
    a = 8'hFF; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_check(8'h00, 1'b1, -1, 1'b0);
    @(negedge clk);
    chk("ripple_done_one_cycle", {31'd0, done}, 32'd0);
    chk("ripple_idle_busy", {31'd0, busy}, 32'd0);

    // A5 + 5A = 0_FF, then 80 + 80 = 1_00 with start held high
    a = 8'hA5; b = 8'h5A; start = 1'b1;
    @(negedge clk);
    a = 8'h80; b = 8'h80;
    op_check(8'hFF, 1'b0, -1, 1'b1);
    @(negedge clk);
    chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
    chk("b2b_gap_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("b2b_second_accept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    op_check(8'h00, 1'b1, -1, 1'b0);
    @(negedge clk);

    // Starts during RUN and FIN are ignored: 03 + 04 = 0_07
    a = 8'h03; b = 8'h04; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_check(8'h07, 1'b0, 2, 1'b0);
    start = 1'b1; a = 8'hF0; b = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    chk("fin_start_busy", {31'd0, busy}, 32'd0);
    chk("fin_start_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("no_second_op_busy", {31'd0, busy}, 32'd0);
    chk("no_second_op_done", {31'd0, done}, 32'd0);
    chk("no_second_op_sum", {24'd0, sum}, 32'h07);

    // Abort mid-RUN, then restart immediately: 10 + 20 = 0_30
    a = 8'h7F; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("abort_pre_busy", {31'd0, busy}, 32'd1);
      chk("abort_pre_sum", {24'd0, sum}, {24'd0, hold_sum});
      if (k == 3) rst = 1'b1;
      @(negedge clk);
    end
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    hold_sum  = 8'h00;
    hold_cout = 1'b0;
    rst = 1'b0; start = 1'b1; a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 1'b0;
    op_check(8'h30, 1'b0, -1, 1'b0);
    @(negedge clk);
    chk("restart_done_one_cycle", {31'd0, done}, 32'd0);

    // Exhaustive WIDTH=4, one accept every WIDTH+2 cycles
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i); b4 = 4'(j); start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("x4_early_done", {31'd0, done4}, 32'd0);
        @(negedge clk);
        chk("x4_done", {31'd0, done4}, 32'd1);
        chk("x4_result", {27'd0, cout4, sum4}, 32'(i + j));
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
